// File: rtl/sat_updown_counter.sv
// Saturating / wrapping up-down counter with clamped step and overflow/underflow pulses.
// Define UPDOWN_COUNTER_LOAD_EN to add the Load_i/LoadVal_i synchronous load port.
module sat_updown_counter #(
  parameter int unsigned      WIDTH     = 3,
  parameter logic [WIDTH-1:0] MIN_VAL   = '0,
  parameter logic [WIDTH-1:0] MAX_VAL   = '1,
  parameter logic [WIDTH-1:0] RESET_VAL = MIN_VAL,
  parameter int unsigned      WRAP      = 0
) (
  input  logic             Clock_i,
  input  logic             Reset_i,
  input  logic             Enable_i,
  input  logic             Up_i,
  input  logic             Down_i,
  input  logic [WIDTH-1:0] Step_i,
`ifdef UPDOWN_COUNTER_LOAD_EN
  input  logic             Load_i,
  input  logic [WIDTH-1:0] LoadVal_i,
`endif
  output logic [WIDTH-1:0] Count_o,
  output logic             AtMin_o,
  output logic             AtMax_o,
  output logic             Ovf_o,
  output logic             Unf_o
);

  typedef logic [WIDTH:0] ext_t;

  // One extra bit so RANGE (up to 2**WIDTH) and count+step never lose a carry.
  localparam ext_t MIN_X = {1'b0, MIN_VAL};
  localparam ext_t MAX_X = {1'b0, MAX_VAL};
  localparam ext_t RANGE = MAX_X - MIN_X + ext_t'(1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  ext_t step_x;
  ext_t step_eff;
  ext_t cnt_x;
  ext_t sum_x;
  ext_t floor_x;
  ext_t next_x;
`ifdef UPDOWN_COUNTER_LOAD_EN
  ext_t load_x;
`endif

  always_comb begin
    step_x   = {1'b0, Step_i};
    step_eff = (step_x > RANGE) ? RANGE : step_x;
    cnt_x    = {1'b0, count_q};
    sum_x    = cnt_x + step_eff;
    // count - step >= MIN_VAL rewritten so no negative intermediate is needed
    floor_x  = MIN_X + step_eff;
    next_x   = cnt_x;
    ovf_d    = 1'b0;
    unf_d    = 1'b0;
`ifdef UPDOWN_COUNTER_LOAD_EN
    load_x   = {1'b0, LoadVal_i};
`endif
    if (Enable_i) begin
`ifdef UPDOWN_COUNTER_LOAD_EN
      if (Load_i) begin
        if (load_x < MIN_X)      next_x = MIN_X;
        else if (load_x > MAX_X) next_x = MAX_X;
        else                     next_x = load_x;
      end else
`endif
      if (Up_i) begin
        if (sum_x > MAX_X) begin
          ovf_d  = 1'b1;
          next_x = (WRAP != 0) ? (sum_x - RANGE) : MAX_X;
        end else begin
          next_x = sum_x;
        end
      end else if (Down_i) begin
        if (cnt_x < floor_x) begin
          unf_d  = 1'b1;
          next_x = (WRAP != 0) ? (cnt_x + RANGE - step_eff) : MIN_X;
        end else begin
          next_x = cnt_x - step_eff;
        end
      end
    end
    count_d = WIDTH'(next_x);
  end

  always_ff @(posedge Clock_i) begin
    if (Reset_i) begin
      count_q <= RESET_VAL;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign Count_o = count_q;
  assign AtMin_o = (count_q == MIN_VAL);
  assign AtMax_o = (count_q == MAX_VAL);
  assign Ovf_o   = ovf_q;
  assign Unf_o   = unf_q;

endmodule

// File: tb/tb_sat_updown_counter.sv
// Scoreboard bench for sat_updown_counter: three parameterisations driven by directed vectors.
// Load vectors are exercised only when UPDOWN_COUNTER_LOAD_EN is defined.
module tb_sat_updown_counter;

  logic clk;
  int   cyc;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // dut_a: defaults (W3, 0..7, saturate)
  logic       a_rst, a_en, a_up, a_dn;
  logic [2:0] a_step, a_cnt;
  logic       a_amin, a_amax, a_ovf, a_unf;
  // dut_b: W4, 3..12, wrap
  logic       b_rst, b_en, b_up, b_dn;
  logic [3:0] b_step, b_cnt;
  logic       b_amin, b_amax, b_ovf, b_unf;
  // dut_c: W3, 2..5, saturate (load tests when enabled)
  logic       c_rst, c_en, c_up, c_dn;
  logic [2:0] c_step, c_cnt;
  logic       c_amin, c_amax, c_ovf, c_unf;
`ifdef UPDOWN_COUNTER_LOAD_EN
  logic       c_ld;
  logic [2:0] c_ldv;
`endif

  sat_updown_counter dut_a (
    .Clock_i(clk), .Reset_i(a_rst), .Enable_i(a_en), .Up_i(a_up), .Down_i(a_dn),
    .Step_i(a_step),
`ifdef UPDOWN_COUNTER_LOAD_EN
    .Load_i(1'b0), .LoadVal_i(3'd0),
`endif
    .Count_o(a_cnt), .AtMin_o(a_amin), .AtMax_o(a_amax), .Ovf_o(a_ovf), .Unf_o(a_unf)
  );

  sat_updown_counter #(.WIDTH(4), .MIN_VAL(4'd3), .MAX_VAL(4'd12), .RESET_VAL(4'd3), .WRAP(1)) dut_b (
    .Clock_i(clk), .Reset_i(b_rst), .Enable_i(b_en), .Up_i(b_up), .Down_i(b_dn),
    .Step_i(b_step),
`ifdef UPDOWN_COUNTER_LOAD_EN
    .Load_i(1'b0), .LoadVal_i(4'd0),
`endif
    .Count_o(b_cnt), .AtMin_o(b_amin), .AtMax_o(b_amax), .Ovf_o(b_ovf), .Unf_o(b_unf)
  );

  sat_updown_counter #(.WIDTH(3), .MIN_VAL(3'd2), .MAX_VAL(3'd5), .RESET_VAL(3'd2), .WRAP(0)) dut_c (
    .Clock_i(clk), .Reset_i(c_rst), .Enable_i(c_en), .Up_i(c_up), .Down_i(c_dn),
    .Step_i(c_step),
`ifdef UPDOWN_COUNTER_LOAD_EN
    .Load_i(c_ld), .LoadVal_i(c_ldv),
`endif
    .Count_o(c_cnt), .AtMin_o(c_amin), .AtMax_o(c_amax), .Ovf_o(c_ovf), .Unf_o(c_unf)
  );

  typedef struct {
    int         dut;
    int         cyc;
    int         idx;
    logic [7:0] exp;
  } exp_t;

  exp_t q[$];
  int   n_vec;
  int   n_err;
  int   n_idx;

  // Apply one vector and queue the response expected after the next edge.
  task automatic v(input int dut, input logic rst, input logic en, input logic up,
                   input logic dn, input logic [3:0] st, input logic ld,
                   input logic [3:0] ldv, input logic [3:0] cnt, input logic ovf,
                   input logic unf, input logic amin, input logic amax);
    exp_t e;
    @(posedge clk);
    #1;
    case (dut)
      0: begin a_rst = rst; a_en = en; a_up = up; a_dn = dn; a_step = st[2:0]; end
      1: begin b_rst = rst; b_en = en; b_up = up; b_dn = dn; b_step = st; end
      default: begin
        c_rst = rst; c_en = en; c_up = up; c_dn = dn; c_step = st[2:0];
`ifdef UPDOWN_COUNTER_LOAD_EN
        c_ld = ld; c_ldv = ldv[2:0];
`endif
      end
    endcase
    e.dut = dut;
    e.cyc = cyc + 1;
    e.idx = n_idx;
    e.exp = {cnt, ovf, unf, amin, amax};
    n_idx++;
    q.push_back(e);
    if (ld && ldv == 4'hf) $display("unused-load-pattern");
  endtask

  // Monitor: compare the DUT outputs against whatever expectation is due this cycle.
  initial begin
    exp_t       e;
    logic [7:0] act;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        case (e.dut)
          0:       act = {1'b0, a_cnt, a_ovf, a_unf, a_amin, a_amax};
          1:       act = {b_cnt, b_ovf, b_unf, b_amin, b_amax};
          default: act = {1'b0, c_cnt, c_ovf, c_unf, c_amin, c_amax};
        endcase
        n_vec++;
        if (act !== e.exp) begin
          n_err++;
          $display("FAIL dut%0d vec%0d: got cnt=%0d ovf=%b unf=%b amin=%b amax=%b, want cnt=%0d ovf=%b unf=%b amin=%b amax=%b",
                   e.dut, e.idx, act[7:4], act[3], act[2], act[1], act[0],
                   e.exp[7:4], e.exp[3], e.exp[2], e.exp[1], e.exp[0]);
        end
      end
    end
  end

  initial begin
    n_vec = 0; n_err = 0; n_idx = 0; cyc = 0;
    a_rst = 1; a_en = 0; a_up = 0; a_dn = 0; a_step = '0;
    b_rst = 1; b_en = 0; b_up = 0; b_dn = 0; b_step = '0;
    c_rst = 1; c_en = 0; c_up = 0; c_dn = 0; c_step = '0;
`ifdef UPDOWN_COUNTER_LOAD_EN
    c_ld = 0; c_ldv = '0;
`endif

    //  dut rst en up dn step ld ldv   cnt ovf unf amin amax
    v(0, 1, 0, 0, 0, 4'd1, 0, 4'd0, 4'd0, 0, 0, 1, 0);
    v(0, 0, 1, 1, 0, 4'd1, 0, 4'd0, 4'd1, 0, 0, 0, 0);
    v(0, 0, 1, 1, 0, 4'd1, 0, 4'd0, 4'd2, 0, 0, 0, 0);
    v(0, 0, 1, 1, 0, 4'd1, 0, 4'd0, 4'd3, 0, 0, 0, 0);
    v(0, 0, 1, 1, 0, 4'd1, 0, 4'd0, 4'd4, 0, 0, 0, 0);
    v(0, 0, 1, 1, 0, 4'd1, 0, 4'd0, 4'd5, 0, 0, 0, 0);
    v(0, 0, 1, 1, 0, 4'd1, 0, 4'd0, 4'd6, 0, 0, 0, 0);
    v(0, 0, 1, 1, 0, 4'd1, 0, 4'd0, 4'd7, 0, 0, 0, 1);
    v(0, 0, 1, 1, 0, 4'd1, 0, 4'd0, 4'd7, 1, 0, 0, 1);
    v(0, 0, 1, 1, 0, 4'd1, 0, 4'd0, 4'd7, 1, 0, 0, 1);
    v(0, 0, 0, 1, 0, 4'd1, 0, 4'd0, 4'd7, 0, 0, 0, 1);
    v(0, 0, 1, 0, 0, 4'd1, 0, 4'd0, 4'd7, 0, 0, 0, 1);
    v(0, 0, 1, 0, 1, 4'd3, 0, 4'd0, 4'd4, 0, 0, 0, 0);
    v(0, 0, 1, 0, 1, 4'd0, 0, 4'd0, 4'd4, 0, 0, 0, 0);
    v(0, 0, 1, 0, 1, 4'd7, 0, 4'd0, 4'd0, 0, 1, 1, 0);
    v(0, 0, 1, 0, 1, 4'd1, 0, 4'd0, 4'd0, 0, 1, 1, 0);
    v(0, 0, 1, 1, 0, 4'd2, 0, 4'd0, 4'd2, 0, 0, 0, 0);
    v(0, 0, 1, 1, 1, 4'd1, 0, 4'd0, 4'd3, 0, 0, 0, 0);
    v(0, 0, 0, 1, 0, 4'd1, 0, 4'd0, 4'd3, 0, 0, 0, 0);
    v(0, 0, 1, 1, 0, 4'd3, 0, 4'd0, 4'd6, 0, 0, 0, 0);
    v(0, 1, 1, 1, 0, 4'd1, 0, 4'd0, 4'd0, 0, 0, 1, 0);
    v(0, 0, 1, 1, 0, 4'd7, 0, 4'd0, 4'd7, 0, 0, 0, 1);
    v(0, 0, 1, 1, 0, 4'd1, 0, 4'd0, 4'd7, 1, 0, 0, 1);
    v(0, 1, 0, 0, 0, 4'd1, 0, 4'd0, 4'd0, 0, 0, 1, 0);

    v(1, 1, 0, 0, 0, 4'd0,  0, 4'd0, 4'd3,  0, 0, 1, 0);
    v(1, 0, 1, 1, 0, 4'd7,  0, 4'd0, 4'd10, 0, 0, 0, 0);
    v(1, 0, 1, 1, 0, 4'd5,  0, 4'd0, 4'd5,  1, 0, 0, 0);
    v(1, 0, 1, 0, 1, 4'd1,  0, 4'd0, 4'd4,  0, 0, 0, 0);
    v(1, 0, 1, 0, 1, 4'd3,  0, 4'd0, 4'd11, 0, 1, 0, 0);
    v(1, 0, 1, 1, 0, 4'd1,  0, 4'd0, 4'd12, 0, 0, 0, 1);
    v(1, 0, 1, 0, 0, 4'd1,  0, 4'd0, 4'd12, 0, 0, 0, 1);
    v(1, 0, 1, 1, 0, 4'd1,  0, 4'd0, 4'd3,  1, 0, 1, 0);
    v(1, 0, 1, 1, 0, 4'd1,  0, 4'd0, 4'd4,  0, 0, 0, 0);
    v(1, 0, 1, 0, 1, 4'd15, 0, 4'd0, 4'd4,  0, 1, 0, 0);
    v(1, 0, 1, 1, 0, 4'd15, 0, 4'd0, 4'd4,  1, 0, 0, 0);
    v(1, 0, 1, 0, 1, 4'd0,  0, 4'd0, 4'd4,  0, 0, 0, 0);
    v(1, 0, 1, 1, 0, 4'd8,  0, 4'd0, 4'd12, 0, 0, 0, 1);
    v(1, 0, 1, 0, 1, 4'd9,  0, 4'd0, 4'd3,  0, 0, 1, 0);
    v(1, 1, 1, 1, 0, 4'd1,  0, 4'd0, 4'd3,  0, 0, 1, 0);

    v(2, 1, 0, 0, 0, 4'd0, 0, 4'd0, 4'd2, 0, 0, 1, 0);
    v(2, 0, 1, 0, 1, 4'd1, 0, 4'd0, 4'd2, 0, 1, 1, 0);
    v(2, 0, 1, 1, 0, 4'd7, 0, 4'd0, 4'd5, 1, 0, 0, 1);
    v(2, 0, 1, 0, 1, 4'd2, 0, 4'd0, 4'd3, 0, 0, 0, 0);
    v(2, 0, 1, 1, 1, 4'd1, 0, 4'd0, 4'd4, 0, 0, 0, 0);
`ifdef UPDOWN_COUNTER_LOAD_EN
    v(2, 0, 1, 1, 0, 4'd1, 1, 4'd7, 4'd5, 0, 0, 0, 1);
    v(2, 0, 1, 0, 1, 4'd1, 1, 4'd0, 4'd2, 0, 0, 1, 0);
    v(2, 0, 1, 0, 0, 4'd1, 1, 4'd4, 4'd4, 0, 0, 0, 0);
    v(2, 0, 0, 0, 0, 4'd1, 1, 4'd3, 4'd4, 0, 0, 0, 0);
    v(2, 1, 1, 1, 0, 4'd1, 1, 4'd5, 4'd2, 0, 0, 1, 0);
`endif

    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expectations, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sat_updown_counter.md
SAT_UPDOWN_COUNTER -- requirements
Module: sat_updown_counter

Interface
REQ-001 Parameters SHALL be, one per line:
- WIDTH, 3, counter width in bits (2..32).
- MIN_VAL, 0, lower bound of the count range.
- MAX_VAL, 2**WIDTH-1, upper bound of the count range; MIN_VAL < MAX_VAL <= 2**WIDTH-1.
- RESET_VAL, MIN_VAL, count after reset; MIN_VAL <= RESET_VAL <= MAX_VAL.
- WRAP, 0, 0 = saturate at the bounds, 1 = wrap modulo RANGE.
REQ-002 Ports SHALL be, one per line:
- Clock_i  in  1  sole clock; all state updates on its rising edge.
- Reset_i  in  1  synchronous, active-high reset.
- Enable_i  in  1  count enable; when low, count and flags hold and pulses clear.
- Up_i  in  1  increment request.
- Down_i  in  1  decrement request.
- Step_i  in  WIDTH  step magnitude, unsigned.
- Load_i  in  1  synchronous load request (UPDOWN_COUNTER_LOAD_EN only).
- LoadVal_i  in  WIDTH  load value (UPDOWN_COUNTER_LOAD_EN only).
- Count_o  out  WIDTH  registered present count.
- AtMin_o  out  1  high when Count_o == MIN_VAL.
- AtMax_o  out  1  high when Count_o == MAX_VAL.
- Ovf_o  out  1  one-cycle pulse: last update crossed MAX_VAL (saturated or wrapped).
- Unf_o  out  1  one-cycle pulse: last update crossed MIN_VAL (saturated or wrapped).

Function
REQ-003 RANGE SHALL be MAX_VAL-MIN_VAL+1; all intermediate arithmetic SHALL use WIDTH+1 bits so no carry is lost.
REQ-004 Effective step SHALL be min(Step_i, RANGE); step 0 SHALL leave Count_o unchanged and raise no pulse.
REQ-005 Priority per enabled cycle SHALL be: Load_i > Up_i > Down_i > hold; Up_i and Down_i together SHALL act as Up_i only.
REQ-006 Up, WRAP=0: next = Count+step if Count+step <= MAX_VAL, else MAX_VAL with Ovf_o pulsed.
REQ-007 Up, WRAP=1: next = Count+step if Count+step <= MAX_VAL, else Count+step-RANGE with Ovf_o pulsed.
REQ-008 Down, WRAP=0: next = Count-step if Count-step >= MIN_VAL, else MIN_VAL with Unf_o pulsed.
REQ-009 Down, WRAP=1: next = Count-step if Count-step >= MIN_VAL, else Count-step+RANGE with Unf_o pulsed.
REQ-010 Up at MAX_VAL with WRAP=0 SHALL hold MAX_VAL and pulse Ovf_o; Down at MIN_VAL with WRAP=0 SHALL hold MIN_VAL and pulse Unf_o.
REQ-011 Ovf_o/Unf_o SHALL be registered and assert in the same cycle Count_o shows the new value; they SHALL deassert the next cycle unless re-triggered; both SHALL never be high together.
REQ-012 AtMin_o/AtMax_o SHALL be combinational decodes of Count_o with zero added latency.
REQ-013 Count_o SHALL change exactly one cycle after the sampled request (latency 1) and SHALL never leave [MIN_VAL, MAX_VAL].

Reset
REQ-014 With Reset_i high at a clock edge: Count_o = RESET_VAL and Ovf_o = Unf_o = 0; AtMin_o/AtMax_o follow REQ-012.
REQ-015 Reset SHALL take priority over Enable_i, Load_i, Up_i and Down_i, including mid-sequence; counting SHALL resume from RESET_VAL on the first edge after release.

Configuration
REQ-016 Macro UPDOWN_COUNTER_LOAD_EN defined: Load_i/LoadVal_i SHALL exist; an enabled load SHALL set Count = LoadVal_i clamped to [MIN_VAL, MAX_VAL] and SHALL pulse neither Ovf_o nor Unf_o.
REQ-017 Macro undefined: Load_i/LoadVal_i SHALL be absent, with no load logic; all other behaviour identical.

Verification
REQ-018 Defaults (WIDTH=3, saturate), Step=1, Up held 9 cycles after reset -> Count 1..7 then holds 7; Ovf_o high on cycles 8 and 9; AtMax_o high from cycle 7.
REQ-019 WIDTH=4, MIN_VAL=3, MAX_VAL=12, WRAP=1, Count=10, Up with Step=5 -> Count=5, Ovf_o pulses 1 cycle.
REQ-020 Same config, Count=4, Down with Step=3 -> Count=11, Unf_o pulses; Step=15 (clamped to 10) from 4 -> Count=4 with Unf_o.
REQ-021 Up and Down both high at Count=2 (defaults) -> Count=3; Enable_i low with Up high -> Count holds, no pulse.
REQ-022 Reset_i asserted at Count=6 while Up high -> next Count=RESET_VAL, pulses 0.
REQ-023 LOAD_EN build, MIN_VAL=2, MAX_VAL=5: Load_i with LoadVal_i=7 and Up high -> Count=5, Ovf_o=0; LoadVal_i=0 -> Count=2, Unf_o=0.
